// File: rtl/ahb_gpio_arbiter.sv
// ahb_gpio_arbiter
// Shares one AHB-Lite GPIO slave port between two single-beat command
// sources. One NONSEQ transfer is in flight at a time; slave wait states are
// honoured through HREADYOUT and each command completes with a one-cycle ack.
//
// Build option: define GPIO_ARB_FIXED_PRI_EN to make requester 0 win every
// contested arbitration (the round-robin pointer is then removed). Without
// it, the last-granted requester has the lowest priority.
//
// Requester handshake: a requester raises req[i] with we/addr/wdata valid and
// holds req until it sees ack[i]. The command fields are captured at the
// grant edge and ignored afterwards. In the ack cycle req[i] is masked, so the
// requester may drop req or present its next command during that cycle.
// gnt[i] marks the owner from the grant edge until the ack edge.

module ahb_gpio_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester side
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        gnt,
  output logic              busy,
  // AHB-Lite master side toward the GPIO slave
  output logic              HSEL,
  output logic [1:0]        HTRANS,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [DATA_W-1:0] HWDATA,
  output logic              HREADY,
  input  logic              HREADYOUT,
  input  logic [DATA_W-1:0] HRDATA,
  // debug view of the transfer FSM
  output logic [1:0]        dbg_state_o
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_DATA = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                hsel_q, hsel_d;
  logic [1:0]          htrans_q, htrans_d;
  logic [ADDR_W-1:0]   haddr_q, haddr_d;
  logic                hwrite_q, hwrite_d;
  logic [DATA_W-1:0]   hwdata_q, hwdata_d;
  // write data is held here until the data phase puts it on HWDATA
  logic [DATA_W-1:0]   wdata_q, wdata_d;

`ifndef GPIO_ARB_FIXED_PRI_EN
  // index of the requester that wins a tie; points away from the last grant
  logic                prio_q, prio_d;
`endif

  logic [1:0]          elig;
  logic                win_valid;
  logic                win_id;

  // Arbitration: the requester acked this cycle is not eligible again yet.
  always_comb begin
    elig      = req & ~ack_q;
    win_valid = |elig;
`ifdef GPIO_ARB_FIXED_PRI_EN
    // requester 0 wins whenever it is eligible
    win_id    = ~elig[0];
`else
    if (elig == 2'b11) begin
      win_id = prio_q;
    end else begin
      win_id = elig[1];
    end
`endif
  end

  // Next-state and registered-output logic of the transfer FSM.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ack_d    = 2'b00;
    rdata_d  = rdata_q;
    hsel_d   = hsel_q;
    htrans_d = htrans_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;
    wdata_d  = wdata_q;
`ifndef GPIO_ARB_FIXED_PRI_EN
    prio_d   = prio_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          state_d  = S_ADDR;
          gnt_d    = win_id ? 2'b10 : 2'b01;
          hsel_d   = 1'b1;
          htrans_d = HTRANS_NONSEQ;
          haddr_d  = win_id ? addr1 : addr0;
          hwrite_d = we[win_id];
          wdata_d  = win_id ? wdata1 : wdata0;
`ifndef GPIO_ARB_FIXED_PRI_EN
          prio_d   = ~win_id;
`endif
        end
      end

      S_ADDR: begin
        // address phase is held unchanged while the slave stalls
        if (HREADYOUT) begin
          state_d  = S_DATA;
          hsel_d   = 1'b0;
          htrans_d = HTRANS_IDLE;
          if (hwrite_q) begin
            hwdata_d = wdata_q;
          end
        end
      end

      S_DATA: begin
        if (HREADYOUT) begin
          state_d = S_IDLE;
          ack_d   = gnt_q;
          gnt_d   = 2'b00;
          if (!hwrite_q) begin
            rdata_d = HRDATA;
          end
        end
      end

      default: begin
        state_d  = S_IDLE;
        gnt_d    = 2'b00;
        hsel_d   = 1'b0;
        htrans_d = HTRANS_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any in-flight command silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gnt_q    <= 2'b00;
      ack_q    <= 2'b00;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      hsel_q   <= 1'b0;
      htrans_q <= HTRANS_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      hsel_q   <= hsel_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
      wdata_q  <= wdata_d;
    end
  end

`ifndef GPIO_ARB_FIXED_PRI_EN
  // Round-robin pointer; requester 0 has priority out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`endif

  // Single slave, so the bus-wide HREADY is the slave's own ready.
  assign HREADY      = HREADYOUT;

  assign gnt         = gnt_q;
  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign HSEL        = hsel_q;
  assign HTRANS      = htrans_q;
  assign HADDR       = haddr_q;
  assign HWRITE      = hwrite_q;
  assign HWDATA      = hwdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/ahb_gpio_arbiter.md
# ahb_gpio_arbiter

Two-requester AHB-Lite master arbiter that shares the single AHB GPIO slave port between two independent command sources, e.g. a test sequencer and a software-model bridge. Each requester issues single-beat read/write commands through a req/ack handshake. The block round-robins between requesters, runs one NONSEQ single transfer at a time on the AHB side, honours slave wait states via HREADYOUT, and returns read data with a one-cycle ack pulse.

## Interface
- ADDR_W, 32, AHB address width
- DATA_W, 32, AHB data width (GPIO uses low 16 bits)

- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  2  per-requester command request, bit i = requester i
- we  input  2  per-requester write enable (1 = write)
- addr0 / addr1  input  ADDR_W  requester command address
- wdata0 / wdata1  input  DATA_W  requester write data
- ack  output  2  one-cycle completion pulse per requester
- rdata  output  DATA_W  read data, valid while the corresponding ack bit is high
- gnt  output  2  one-hot current owner, 0 when idle
- busy  output  1  transfer in progress
- HSEL, HTRANS[1:0], HADDR[ADDR_W-1:0], HWRITE, HWDATA[DATA_W-1:0], HREADY  output  AHB-Lite master side toward GPIO slave
- HREADYOUT  input  1  slave ready
- HRDATA  input  DATA_W  slave read data

## Operation
- States: IDLE, ADDR, DATA.
- IDLE: pick a winner among eligible req bits; on a winner, latch its we/addr/wdata, set gnt, go to ADDR. No req: stay IDLE.
- Arbitration: round-robin; the last-granted requester has lowest priority. After reset, requester 0 has priority.
- ADDR (address phase): HSEL=1, HTRANS=2'b10 (NONSEQ), HADDR/HWRITE from latched command. At a rising edge with HREADYOUT=1, go to DATA. HREADYOUT=0 holds ADDR with all address-phase outputs stable.
- DATA (data phase): HSEL=0, HTRANS=2'b00 (IDLE), HWDATA=latched wdata (writes). At the rising edge with HREADYOUT=1: capture HRDATA into rdata (reads only; writes leave rdata unchanged), pulse ack[gnt], clear gnt, go to IDLE. HREADYOUT=0 holds DATA.
- Ack cycle: the acked requester's req is masked in that IDLE cycle. The other requester may be granted in the same cycle. The acked requester must drop req or re-request from the next cycle.
- Command inputs are sampled only at the grant edge. Later changes are ignored until ack.
- HREADY = HREADYOUT (combinational loop-back, single slave).
- busy = 1 in ADDR and DATA.
- Reset mid-transfer: immediately returns to IDLE with all outputs at their reset values. The in-flight command is dropped with no ack.

## Timing
- Reset values: HSEL=0, HTRANS=2'b00, HADDR=0, HWRITE=0, HWDATA=0, ack=0, rdata=0, gnt=0, busy=0. Priority pointer selects requester 0.
- All outputs are registered except HREADY.
- Zero-wait latency: req high at edge N (IDLE) → address phase cycle N+1 → data phase cycle N+2 → ack high cycle N+3.
- Each HREADYOUT=0 cycle in ADDR or DATA adds one cycle.
- Back-to-back: a pending second requester is granted in the ack cycle. Its address phase starts the following cycle, giving 3 cycles per zero-wait transfer.
- Simultaneous req with equal standing: the round-robin pointer decides. gnt is never two-hot.

## Configuration
- GPIO_ARB_FIXED_PRI_EN defined: requester 0 always wins when both request, and the round-robin pointer is removed. Ack-cycle masking still applies, so requester 1 can win the ack cycle after a requester-0 transfer.
- Not defined: round-robin as described in Operation.

## Test plan
- Single write: req=2'b01, we0=1, addr0=0x0000_0004, wdata0=0x0000_A5A5, HREADYOUT=1 → NONSEQ address phase with HADDR=0x4, HWRITE=1 in cycle N+1; HWDATA=0xA5A5 in N+2; ack=2'b01 in N+3 only.
- Single read with 2 wait states: req=2'b10, we1=0, addr1=0x0, HREADYOUT low 2 cycles in DATA, HRDATA=0x0000_3C3C → ack=2'b10 in N+5 with rdata=0x3C3C; address-phase outputs stable while waiting.
- Contention: both req held high continuously → grants alternate 0,1,0,1 with a 3-cycle period. With GPIO_ARB_FIXED_PRI_EN, requester 0 wins every arbitration not masked by the ack cycle.
- Wait in address phase: HREADYOUT=0 for 3 cycles during ADDR → HTRANS=2'b10 and HADDR held 3 extra cycles; ack delayed by 3.
- Reset mid-transfer: rst_n low during DATA → all outputs zero immediately, no ack; after release, req=2'b11 grants requester 0 first.
